// File: rtl/mac_drain.sv
// mac_drain: buffers MAC column-result vectors and emits them one requantized
// element per transfer (round half up, optional ReLU, saturate to QW bits).
module mac_drain #(
    parameter int COLUMN = 6,
    parameter int OW     = 24,
    parameter int QW     = 8,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COLUMN*OW-1:0] mac_s_data,
    input  logic                 mac_s_first,
    input  logic                 mac_s_last,
    input  logic                 mac_s_valid,
    output logic                 mac_s_ready,
    input  logic [4:0]           q_shift,
    input  logic                 q_relu,
    output logic [QW-1:0]        out_data,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = COLUMN > 1 ? $clog2(COLUMN) : 1;
    // Wide enough that a shift of up to 31 and its rounding bias never wrap.
    localparam int SW = OW + 33;
    localparam logic signed [SW-1:0] QMAX = (SW'(1) << (QW - 1)) - SW'(1);
    localparam logic signed [SW-1:0] QMIN = ~QMAX;

    typedef enum logic {IDLE, EMIT} state_t;

    logic [COLUMN*OW-1:0] r_data  [DEPTH];
    logic                 r_first [DEPTH];
    logic                 r_last  [DEPTH];
    logic                 r_relu  [DEPTH];
    logic [4:0]           r_shift [DEPTH];
    logic [AW-1:0]        r_wp, r_rp;
    logic [AW:0]          r_cnt, w_cnt_nxt;
    logic                 r_ready;
    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_col, w_col_nxt;
    logic                 w_push, w_pop, w_xfer, w_col_last;
    logic [OW-1:0]        w_col_val;
    logic [4:0]           w_s;
    logic signed [SW-1:0] w_x, w_rnd, w_sum, w_sh;
    logic [QW-1:0]        w_q;

    assign mac_s_ready = r_ready;
    assign w_push      = mac_s_valid & r_ready;
    assign out_valid   = r_state == EMIT;
    assign w_xfer      = out_valid & out_ready;
    assign w_col_last  = r_col == CW'(COLUMN - 1);
    assign w_pop       = w_xfer & w_col_last;
    assign w_cnt_nxt   = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

    // A push in the same cycle counts, so an empty buffer shows data one cycle after accept.
    always_comb begin
        w_state_nxt = (r_state == EMIT && !w_pop) ? EMIT : (w_cnt_nxt != '0 ? EMIT : IDLE);
        w_col_nxt   = w_xfer ? (w_col_last ? '0 : r_col + CW'(1)) : r_col;
    end

    always_comb begin
        w_col_val = r_data[r_rp][r_col*OW +: OW];
        w_s       = r_shift[r_rp];
        w_x       = {{(SW-OW){w_col_val[OW-1]}}, w_col_val};
        w_rnd     = (w_s != 5'd0) ? (SW'(1) << (w_s - 5'd1)) : '0;
        w_sum     = w_x + w_rnd;
        w_sh      = w_sum >>> w_s;
        w_q       = (r_relu[r_rp] && w_sh < 0) ? '0 :
                    (w_sh > QMAX) ? QMAX[QW-1:0] :
                    (w_sh < QMIN) ? QMIN[QW-1:0] : w_sh[QW-1:0];
        out_data  = out_valid ? w_q : '0;
        out_first = out_valid & r_first[r_rp] & (r_col == '0);
        out_last  = out_valid & r_last[r_rp] & w_col_last;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wp]  <= mac_s_data;
            r_first[r_wp] <= mac_s_first;
            r_last[r_wp]  <= mac_s_last;
            r_shift[r_wp] <= q_shift;
            r_relu[r_wp]  <= q_relu;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= IDLE;
            r_col   <= '0;
        end else begin
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= r_rp + AW'(w_pop);
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_cnt_nxt < (AW+1)'(DEPTH);
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
        end
    end
endmodule

// File: tb/tb_mac_drain.sv
// tb_mac_drain: directed vectors with hand-computed results; a scoreboard queue
// is filled at stimulus time and drained by an independent output monitor.
module tb_mac_drain;
    localparam int COLUMN = 6, OW = 24, QW = 8, DEPTH = 2;

    logic                 clk = 0, rst_n = 0;
    logic [COLUMN*OW-1:0] mac_s_data = '0;
    logic                 mac_s_first = 0, mac_s_last = 0, mac_s_valid = 0, mac_s_ready;
    logic [4:0]           q_shift = '0;
    logic                 q_relu = 0;
    logic [QW-1:0]        out_data;
    logic                 out_first, out_last, out_valid;
    logic                 out_ready = 0;

    int            tests = 0, fails = 0, cyc = 0, nx = 0, base = 0;
    logic [QW+1:0] sb[$];
    int            xcyc[$];
    logic          rnd_en = 0;
    logic          prev_stall = 0, pf = 0, pl = 0;
    logic [QW-1:0] pd = '0;
    logic [QW+1:0] e;

    int vin[4][6] = '{'{300, -300, 127, 128, -129, 0},
                      '{6, -6, 5, 8388607, -1000, 1000},
                      '{8388607, -8388608, 1, -1, 0, 100},
                      '{-1000, 1000, -1, 0, 2000, -5}};
    int vexp[4][6] = '{'{127, -128, 127, 127, -128, 0},
                       '{2, -1, 1, 127, -128, 127},
                       '{0, 0, 0, 0, 0, 0},
                       '{0, 125, 0, 0, 127, 0}};
    int   vsh[4] = '{0, 2, 31, 3};
    logic vrl[4] = '{0, 0, 0, 1};

    mac_drain #(.COLUMN(COLUMN), .OW(OW), .QW(QW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .mac_s_data(mac_s_data), .mac_s_first(mac_s_first),
        .mac_s_last(mac_s_last), .mac_s_valid(mac_s_valid), .mac_s_ready(mac_s_ready),
        .q_shift(q_shift), .q_relu(q_relu), .out_data(out_data), .out_first(out_first),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(int v, bit f, bit l);
        bit acc = 0;
        for (int k = 0; k < COLUMN; k++) begin
            mac_s_data[k*OW +: OW] = OW'(vin[v][k]);
            sb.push_back({QW'(vexp[v][k]), f && k == 0, l && k == COLUMN - 1});
        end
        mac_s_first = f;
        mac_s_last  = l;
        q_shift     = 5'(vsh[v]);
        q_relu      = vrl[v];
        mac_s_valid = 1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = mac_s_ready;
            @(posedge clk);
            #1;
        end
        mac_s_valid = 0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: vector %0d not accepted", v);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d elements outstanding, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: stability under stall and in-order comparison on transfer.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (prev_stall && out_valid) begin
            chk("stall_data", int'(out_data), int'(pd));
            chk("stall_first", int'(out_first), int'(pf));
            chk("stall_last", int'(out_last), int'(pl));
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: data %0d with empty scoreboard, required none", $signed(out_data));
            end else begin
                e = sb.pop_front();
                chk("data", int'($signed(out_data)), int'($signed(e[QW+1:2])));
                chk("first", int'(out_first), int'(e[1]));
                chk("last", int'(out_last), int'(e[0]));
            end
            nx++;
            xcyc.push_back(cyc);
        end
        prev_stall = out_valid && !out_ready;
        pd = out_data;
        pf = out_first;
        pl = out_last;
    end

    initial begin
        #12;
        chk("rst_ready", int'(mac_s_ready), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_first", int'(out_first), 0);
        chk("rst_last", int'(out_last), 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("ready_before_edge", int'(mac_s_ready), 0);
        @(negedge clk);
        chk("ready_after_edge", int'(mac_s_ready), 1);
        @(posedge clk);
        #1;

        out_ready = 1;
        send(0, 1, 1);
        drain();
        send(1, 0, 0);
        send(2, 0, 0);
        send(3, 0, 0);
        drain();

        out_ready = 0;
        send(0, 1, 0);
        send(1, 0, 0);
        @(negedge clk);
        chk("full_ready_low", int'(mac_s_ready), 0);
        @(posedge clk);
        #1 rnd_en = 1;
        send(3, 0, 1);
        drain();
        rnd_en = 0;
        #1 out_ready = 1;
        drain();

        xcyc.delete();
        send(0, 1, 0);
        send(1, 0, 0);
        send(2, 0, 0);
        send(3, 0, 1);
        drain();
        chk("tp_count", xcyc.size(), 24);
        if (xcyc.size() == 24) chk("tp_span", xcyc[23] - xcyc[0], 23);

        base = nx;
        send(0, 1, 1);
        for (int n = 0; n < 50 && nx < base + 3; n++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_valid", int'(out_valid), 1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_ready", int'(mac_s_ready), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        base = nx;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_silent", nx, base);
        chk("post_rst_valid", int'(out_valid), 0);
        send(1, 1, 1);
        drain();
        chk("post_rst_resume", nx, base + COLUMN);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
